fp_addsub_issue_arbiter: RTL and testbench

Shares one 3-stage pipelined FP32 add/sub unit between NUM_REQ requesters (reservation stations). Round-robin issues at most one operation per cycle, carries each operation's tag alongside the unit's pipeline, and buffers results in a credit-protected output FIFO so a stalled result bus never loses a result. Sits between the FP reservation stations and the FP adder, and drives the FP result broadcast.

---
 rtl/fp_addsub_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp_addsub_issue_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_issue_arbiter.sv
// Round-robin issue of FP32 add/sub ops to a shared pipelined adder,
// with a tag pipe and a credit-protected result FIFO.
module fp_addsub_issue_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int TAG_W      = 6,
  parameter  int LATENCY    = 3,
  parameter  int FIFO_DEPTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [32*NUM_REQ-1:0]    req_a,
  input  logic [32*NUM_REQ-1:0]    req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     flush,
  output logic                     fpu_start,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic                     fpu_sub,
  input  logic [31:0]              fpu_result,
  input  logic                     fpu_exception,
  input  logic                     fpu_done,
  output logic                     out_valid,
  output logic [31:0]              out_result,
  output logic                     out_exception,
  output logic [TAG_W-1:0]         out_tag,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready,
  output logic                     err_unexpected_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0]      res;
    logic             exc;
    logic [TAG_W-1:0] tag;
    logic [ID_W-1:0]  id;
  } ent_t;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [LATENCY-1:0] r_occ;
  logic [LATENCY-1:0] r_live;
  logic [TAG_W-1:0] r_tag [LATENCY];
  logic [ID_W-1:0]  r_id  [LATENCY];
  ent_t             r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             r_err;

  logic             w_found;
  logic [ID_W-1:0]  w_gid;
  logic [ID_W-1:0]  w_cand;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  ent_t             w_head;

  // Search starts just after the last grant and wraps.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_gid   = w_cand;
      end
    end
  end

  assign w_issue   = w_found & ~flush & (r_cnt < CW'(FIFO_DEPTH));
  assign req_ready = w_issue ? (NUM_REQ'(1) << w_gid) : '0;
  assign fpu_start = w_issue;
  assign fpu_a     = w_issue ? req_a[32*w_gid +: 32] : '0;
  assign fpu_b     = w_issue ? req_b[32*w_gid +: 32] : '0;
  assign fpu_sub   = w_issue ? req_sub[w_gid] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ  <= '0;
      r_live <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tag[k] <= '0;
        r_id[k]  <= '0;
      end
    end else begin
      r_occ[0]  <= w_issue;
      r_live[0] <= w_issue;
      r_tag[0]  <= req_tag[TAG_W*w_gid +: TAG_W];
      r_id[0]   <= w_gid;
      for (int k = 1; k < LATENCY; k++) begin
        r_occ[k]  <= r_occ[k-1];
        r_live[k] <= r_live[k-1] & ~flush;
        r_tag[k]  <= r_tag[k-1];
        r_id[k]   <= r_id[k-1];
      end
    end
  end

  assign w_push = fpu_done & r_occ[LATENCY-1] & r_live[LATENCY-1] & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= '{res: fpu_result, exc: fpu_exception,
                                 tag: r_tag[LATENCY-1], id: r_id[LATENCY-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
      r_err    <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_cnt <= r_cnt + CW'(w_issue) - CW'(w_pop);
      end
      if (w_issue) r_rr_ptr <= w_gid;
      if (fpu_done && !r_occ[LATENCY-1]) r_err <= 1'b1;
    end
  end

  assign out_valid           = (r_wptr != r_rptr);
  assign w_head              = r_mem[r_rptr[AW-1:0]];
  assign out_result          = out_valid ? w_head.res : '0;
  assign out_exception       = out_valid ? w_head.exc : 1'b0;
  assign out_tag             = out_valid ? w_head.tag : '0;
  assign out_id              = out_valid ? w_head.id  : '0;
  assign err_unexpected_done = r_err;

endmodule

// File: tb/tb_fp_addsub_issue_arbiter.sv
// Directed bench with a bench-side adder model and an issue-order
// scoreboard for fp_addsub_issue_arbiter.
module tb_fp_addsub_issue_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int L  = 3;
  localparam int D  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [N-1:0]      req_sub;
  logic [TW*N-1:0]   req_tag;
  logic [N-1:0]      req_ready;
  logic              flush;
  logic              fpu_start;
  logic [31:0]       fpu_a;
  logic [31:0]       fpu_b;
  logic              fpu_sub;
  logic [31:0]       fpu_result;
  logic              fpu_exception;
  logic              fpu_done;
  logic              out_valid;
  logic [31:0]       out_result;
  logic              out_exception;
  logic [TW-1:0]     out_tag;
  logic [1:0]        out_id;
  logic              out_ready;
  logic              err_unexpected_done;

  fp_addsub_issue_arbiter #(
    .NUM_REQ(N), .TAG_W(TW), .LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_sub(fpu_sub), .fpu_result(fpu_result),
    .fpu_exception(fpu_exception), .fpu_done(fpu_done),
    .out_valid(out_valid), .out_result(out_result),
    .out_exception(out_exception), .out_tag(out_tag),
    .out_id(out_id), .out_ready(out_ready),
    .err_unexpected_done(err_unexpected_done)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] fmodel(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic s);
    if (a == 32'h3F800000 && b == 32'h40000000 && !s)
      return {1'b0, 32'h40400000};
    if (a == 32'h3FC00000 && b == 32'h3F000000 && s)
      return {1'b0, 32'h3F800000};
    return {a[0] ^ b[0], s ? a - b : a + b};
  endfunction

  // Bench adder: fixed LATENCY pipe
  logic        ad_v [L];
  logic [31:0] ad_a [L];
  logic [31:0] ad_b [L];
  logic        ad_s [L];
  logic        inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        ad_v[k] <= 1'b0; ad_a[k] <= '0; ad_b[k] <= '0; ad_s[k] <= 1'b0;
      end
    end else begin
      ad_v[0] <= fpu_start; ad_a[0] <= fpu_a;
      ad_b[0] <= fpu_b;     ad_s[0] <= fpu_sub;
      for (int k = 1; k < L; k++) begin
        ad_v[k] <= ad_v[k-1]; ad_a[k] <= ad_a[k-1];
        ad_b[k] <= ad_b[k-1]; ad_s[k] <= ad_s[k-1];
      end
    end
  end

  assign fpu_done = ad_v[L-1] | inj;
  assign {fpu_exception, fpu_result} =
    ad_v[L-1] ? fmodel(ad_a[L-1], ad_b[L-1], ad_s[L-1]) : 33'd0;

  typedef struct {
    logic [31:0]   res;
    logic          exc;
    logic [TW-1:0] tag;
    logic [1:0]    id;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            obs_starts = 0;
  int            pend [N];
  logic [31:0]   opa [N];
  logic [31:0]   opb [N];
  logic          ops [N];
  logic [TW-1:0] opt [N];
  int            rr_m;
  logic          err_m;

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic new_op(input int i);
    opa[i] = $urandom;
    opb[i] = $urandom;
    ops[i] = 1'($urandom_range(0, 1));
    opt[i] = TW'($urandom_range(0, 63));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (pend[i] > 0);
      req_a[32*i +: 32]     = opa[i];
      req_b[32*i +: 32]     = opb[i];
      req_sub[i]            = ops[i];
      req_tag[TW*i +: TW]   = opt[i];
    end
  endtask

  task automatic check_cycle();
    logic       any, iss, vis;
    int         gid;
    logic [N-1:0] er;
    exp_t       e;
    logic [32:0] r;
    if (!rst_n) begin
      q.delete(); rr_m = N - 1; err_m = 1'b0;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_start", 64'(fpu_start), 64'd0);
      chk("rst_fpu_a", 64'(fpu_a), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(out_result), 64'd0);
      chk("rst_tag", 64'({out_tag, out_id}), 64'd0);
      chk("rst_err", 64'(err_unexpected_done), 64'd0);
      return;
    end
    any = 1'b0; gid = 0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (rr_m + k) % N;
      if (!any && pend[c] > 0) begin any = 1'b1; gid = c; end
    end
    iss = any && !flush && (q.size() < D);
    er  = iss ? N'(1 << gid) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("fpu_start", 64'(fpu_start), 64'(iss));
    if (iss) begin
      chk("fpu_a", 64'(fpu_a), 64'(opa[gid]));
      chk("fpu_b", 64'(fpu_b), 64'(opb[gid]));
      chk("fpu_sub", 64'(fpu_sub), 64'(ops[gid]));
    end
    vis = (q.size() > 0) && (q[0].cyc + L + 1 <= cyc);
    chk("out_valid", 64'(out_valid), 64'(vis));
    if (vis) begin
      chk("out_result", 64'(out_result), 64'(q[0].res));
      chk("out_exc", 64'(out_exception), 64'(q[0].exc));
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
      chk("out_id", 64'(out_id), 64'(q[0].id));
    end
    chk("err", 64'(err_unexpected_done), 64'(err_m));
    if (fpu_start) obs_starts++;
    if (vis && out_ready && !flush) void'(q.pop_front());
    if (iss) begin
      r = fmodel(opa[gid], opb[gid], ops[gid]);
      e.res = r[31:0]; e.exc = r[32]; e.tag = opt[gid];
      e.id = 2'(gid); e.cyc = cyc;
      q.push_back(e);
      rr_m = gid;
      pend[gid]--;
      if (pend[gid] > 0) new_op(gid);
    end
    if (flush) q.delete();
    if (inj) err_m = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_reqs();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; inj = 1'b0;
    rr_m = N - 1; err_m = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; new_op(i); end
    drive_reqs();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // single add from requester 0
    opa[0] = 32'h3F800000; opb[0] = 32'h40000000; ops[0] = 1'b0;
    opt[0] = 6'd5; pend[0] = 1; drive_reqs();
    repeat (4) step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_result", 64'(out_result), 64'h40400000);
    chk("single_tag", 64'(out_tag), 64'd5);
    chk("single_id", 64'(out_id), 64'd0);
    repeat (4) step();

    // round robin with all requesters busy
    for (int i = 0; i < N; i++) begin pend[i] = 5; new_op(i); end
    drive_reqs();
    repeat (28) step();

    // backpressure: exactly D grants with the bus stalled
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 6; new_op(i); end
    drive_reqs();
    obs_starts = 0;
    repeat (14) step();
    chk("bp_grants", 64'(obs_starts), 64'(D));
    chk("bp_ready", 64'(req_ready), 64'd0);
    out_ready = 1'b1;
    repeat (40) step();

    // subtract from requester 2
    opa[2] = 32'h3FC00000; opb[2] = 32'h3F000000; ops[2] = 1'b1;
    opt[2] = 6'd9; pend[2] = 1; drive_reqs();
    repeat (4) step();
    chk("sub_result", 64'(out_result), 64'h3F800000);
    chk("sub_id", 64'(out_id), 64'd2);
    repeat (4) step();

    // flush with three ops in flight, then a fresh op
    for (int i = 0; i < 3; i++) begin pend[i] = 1; new_op(i); end
    drive_reqs();
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    new_op(3); opt[3] = 6'd33; pend[3] = 1; drive_reqs();
    repeat (4) step();
    chk("flush_new_valid", 64'(out_valid), 64'd1);
    chk("flush_new_tag", 64'(out_tag), 64'd33);
    chk("flush_err", 64'(err_unexpected_done), 64'd0);
    repeat (4) step();

    // stray fpu_done with nothing in flight
    repeat (4) step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    chk("err_sticky", 64'(err_unexpected_done), 64'd1);

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
